// File: rtl/operand_mem_server_if.sv
// Operand fetch bus between host/controller and the operand server.
// Carries the load-phase write port, phase pulses and the read port.
interface operand_mem_server_if;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_sel;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        load_done;
  logic        reload;
  logic        req;
  logic [31:0] addr_a;
  logic [31:0] addr_b;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        data_valid;
  logic        serving;
  logic        err_oob;
  logic [31:0] rd_count;

  modport slave (
    input  wr_valid, wr_sel, wr_addr, wr_data,
    input  load_done, reload,
    input  req, addr_a, addr_b,
    output wr_ready, data_a, data_b,
    output data_valid, serving,
    output err_oob, rd_count
  );

  modport master (
    output wr_valid, wr_sel, wr_addr, wr_data,
    output load_done, reload,
    output req, addr_a, addr_b,
    input  wr_ready, data_a, data_b,
    input  data_valid, serving,
    input  err_oob, rd_count
  );
endinterface

// File: rtl/operand_mem_server.sv
// Operand A/B storage: loaded by the host, then served to the
// matrix controller with a fixed read latency.
module operand_mem_server #(
  parameter int M        = 64,
  parameter int K        = 64,
  parameter int N        = 64,
  parameter int READ_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  operand_mem_server_if.slave bus
);
  localparam int DA  = M * K;
  localparam int DB  = K * N;
  localparam int AWA = (DA > 1) ? $clog2(DA) : 1;
  localparam int AWB = (DB > 1) ? $clog2(DB) : 1;
  localparam int L   = READ_LAT;

  typedef enum logic {
    S_LOAD,
    S_SERVE
  } state_t;

  state_t state, state_n;

  logic [7:0]  mem_a [DA];
  logic [7:0]  mem_b [DB];
  logic [7:0]  pa    [L];
  logic [7:0]  pb    [L];
  logic        vq    [L];
  logic        oaq   [L];
  logic        obq   [L];
  logic [31:0] cnt;
  logic        err;

  logic load_st, enter, acc;
  logic wr_en, wr_oob;
  logic oob_a, oob_b;

  assign load_st = (state == S_LOAD);
  assign enter   = load_st && bus.load_done;
  assign acc     = !load_st && bus.req;
  assign wr_en   = load_st && bus.wr_valid;
  assign wr_oob  = bus.wr_sel
                 ? (bus.wr_addr >= 32'(DB))
                 : (bus.wr_addr >= 32'(DA));
  assign oob_a   = bus.addr_a >= 32'(DA);
  assign oob_b   = bus.addr_b >= 32'(DB);

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  // Phase transitions; stray pulses in the wrong phase are ignored.
  always_comb begin
    state_n = state;
    unique case (state)
      S_LOAD:  if (bus.load_done) state_n = S_SERVE;
      S_SERVE: if (bus.reload)    state_n = S_LOAD;
    endcase
  end

  // Banks plus read data delay line; no reset so it maps to BRAM.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oob && !bus.wr_sel)
      mem_a[bus.wr_addr[AWA-1:0]] <= bus.wr_data;
    if (wr_en && !wr_oob && bus.wr_sel)
      mem_b[bus.wr_addr[AWB-1:0]] <= bus.wr_data;
    pa[0] <= mem_a[bus.addr_a[AWA-1:0]];
    pb[0] <= mem_b[bus.addr_b[AWB-1:0]];
    for (int i = 1; i < L; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  // Beat valid and per-operand range flags travel with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        vq[i]  <= 1'b0;
        oaq[i] <= 1'b0;
        obq[i] <= 1'b0;
      end
    end else begin
      vq[0]  <= acc;
      oaq[0] <= oob_a;
      obq[0] <= oob_b;
      for (int i = 1; i < L; i++) begin
        vq[i]  <= vq[i-1];
        oaq[i] <= oaq[i-1];
        obq[i] <= obq[i-1];
      end
    end
  end

  // Beat counter and sticky range error, both cleared on SERVE entry.
  always_ff @(posedge clk) begin
    if (rst || enter) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (acc && cnt != '1)
        cnt <= cnt + 32'd1;
      if ((wr_en && wr_oob) || (acc && (oob_a || oob_b)))
        err <= 1'b1;
    end
  end

  assign bus.wr_ready   = load_st;
  assign bus.serving    = !load_st;
  assign bus.data_valid = vq[L-1];
  assign bus.data_a     = (vq[L-1] && !oaq[L-1]) ? pa[L-1] : '0;
  assign bus.data_b     = (vq[L-1] && !obq[L-1]) ? pb[L-1] : '0;
  assign bus.err_oob    = err;
  assign bus.rd_count   = cnt;
endmodule

// File: tb/tb_operand_mem_server.sv
// Directed bench: three servers (latency 1, 2, 3) share one stimulus
// stream over 4x4 operands so each latency can be observed.
module tb_operand_mem_server;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  operand_mem_server_if i1 ();
  operand_mem_server_if i2 ();
  operand_mem_server_if i3 ();

  assign i2.wr_valid  = i1.wr_valid;
  assign i2.wr_sel    = i1.wr_sel;
  assign i2.wr_addr   = i1.wr_addr;
  assign i2.wr_data   = i1.wr_data;
  assign i2.load_done = i1.load_done;
  assign i2.reload    = i1.reload;
  assign i2.req       = i1.req;
  assign i2.addr_a    = i1.addr_a;
  assign i2.addr_b    = i1.addr_b;
  assign i3.wr_valid  = i1.wr_valid;
  assign i3.wr_sel    = i1.wr_sel;
  assign i3.wr_addr   = i1.wr_addr;
  assign i3.wr_data   = i1.wr_data;
  assign i3.load_done = i1.load_done;
  assign i3.reload    = i1.reload;
  assign i3.req       = i1.req;
  assign i3.addr_a    = i1.addr_a;
  assign i3.addr_b    = i1.addr_b;

  operand_mem_server #(.M(4), .K(4), .N(4), .READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(i1.slave));
  operand_mem_server #(.M(4), .K(4), .N(4), .READ_LAT(2)) u2 (
    .clk(clk), .rst(rst), .bus(i2.slave));
  operand_mem_server #(.M(4), .K(4), .N(4), .READ_LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(i3.slave));

  function automatic logic [7:0] av(int i);
    return 8'(i - 8);
  endfunction

  function automatic logic [7:0] bv(int i);
    return 8'(3 * i - 20);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input int b);
    i1.req    = 1'b1;
    i1.addr_a = 32'(a);
    i1.addr_b = 32'(b);
  endtask

  task automatic wr(input logic s, input int a, input logic [7:0] d);
    i1.wr_valid = 1'b1;
    i1.wr_sel   = s;
    i1.wr_addr  = 32'(a);
    i1.wr_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    i1.wr_valid  = 1'b0;
    i1.wr_sel    = 1'b0;
    i1.wr_addr   = '0;
    i1.wr_data   = '0;
    i1.load_done = 1'b0;
    i1.reload    = 1'b0;
    i1.req       = 1'b0;
    i1.addr_a    = '0;
    i1.addr_b    = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_wr_ready", 32'(i1.wr_ready), 1);
    check("rst_serving", 32'(i1.serving), 0);
    check("rst_valid", 32'(i1.data_valid), 0);
    check("rst_data_a", 32'(i1.data_a), 0);
    check("rst_err", 32'(i1.err_oob), 0);
    check("rst_count", i1.rd_count, 0);

    rd(0, 0);
    step();
    check("load_req_valid", 32'(i1.data_valid), 0);
    i1.req = 1'b0;
    step();
    check("load_req_valid2", 32'(i3.data_valid), 0);
    check("load_req_count", i1.rd_count, 0);

    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, av(i));
      step();
    end
    wr(1'b0, 100, 8'h55);
    step();
    check("load_oob_err", 32'(i1.err_oob), 1);
    for (int i = 0; i < 16; i++) begin
      wr(1'b1, i, bv(i));
      i1.load_done = (i == 15);
      step();
    end
    i1.wr_valid  = 1'b0;
    i1.load_done = 1'b0;
    check("entry_serving", 32'(i1.serving), 1);
    check("entry_wr_ready", 32'(i1.wr_ready), 0);
    check("entry_count", i1.rd_count, 0);
    check("entry_err", 32'(i1.err_oob), 0);

    rd(5, 9);
    step();
    check("l1_v0", 32'(i1.data_valid), 1);
    check("l1_a0", 32'(i1.data_a), 32'(8'hFD));
    check("l1_b0", 32'(i1.data_b), 32'(8'h07));
    rd(15, 0);
    step();
    check("l1_v1", 32'(i1.data_valid), 1);
    check("l1_a1", 32'(i1.data_a), 32'(8'h07));
    check("l1_b1", 32'(i1.data_b), 32'(8'hEC));
    i1.req = 1'b0;
    step();
    check("l1_idle_v", 32'(i1.data_valid), 0);
    check("l1_idle_a", 32'(i1.data_a), 0);
    check("l1_count", i1.rd_count, 2);
    repeat (3) step();

    rd(1, 2);
    step();
    i1.req = 1'b0;
    check("l3_t1_v", 32'(i3.data_valid), 0);
    check("l3_t1_a", 32'(i3.data_a), 0);
    check("l3_t1_b", 32'(i3.data_b), 0);
    step();
    check("l3_t2_v", 32'(i3.data_valid), 0);
    check("l3_t2_a", 32'(i3.data_a), 0);
    check("l3_t2_b", 32'(i3.data_b), 0);
    step();
    check("l3_t3_v", 32'(i3.data_valid), 1);
    check("l3_t3_a", 32'(i3.data_a), 32'(av(1)));
    check("l3_t3_b", 32'(i3.data_b), 32'(bv(2)));
    step();
    check("l3_t4_v", 32'(i3.data_valid), 0);

    for (int c = 0; c < 20; c++) begin
      if (c < 16) rd(c, 15 - c);
      else i1.req = 1'b0;
      step();
      check("burst_v", 32'(i3.data_valid),
            32'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) begin
        check("burst_a", 32'(i3.data_a), 32'(av(c - 2)));
        check("burst_b", 32'(i3.data_b), 32'(bv(17 - c)));
      end
    end
    check("burst_count", i3.rd_count, 19);

    rd(16, 2);
    step();
    i1.req = 1'b0;
    check("oob_v", 32'(i1.data_valid), 1);
    check("oob_a", 32'(i1.data_a), 0);
    check("oob_b", 32'(i1.data_b), 32'(bv(2)));
    check("oob_err", 32'(i1.err_oob), 1);
    check("oob_count", i1.rd_count, 20);
    step();
    step();
    step();
    check("oob_sticky", 32'(i1.err_oob), 1);

    wr(1'b0, 3, 8'h63);
    #1;
    check("serve_wr_ready", 32'(i1.wr_ready), 0);
    step();
    i1.wr_valid = 1'b0;
    rd(3, 3);
    step();
    i1.req = 1'b0;
    check("serve_wr_a", 32'(i1.data_a), 32'(av(3)));
    check("serve_wr_b", 32'(i1.data_b), 32'(bv(3)));
    repeat (3) step();

    for (int c = 0; c < 5; c++) begin
      if (c < 3) rd(6 + c, c);
      else i1.req = 1'b0;
      i1.reload = (c == 2);
      step();
      check("rl_v", 32'(i2.data_valid),
            32'(c >= 1 && c <= 3));
      if (c >= 1 && c <= 3) begin
        check("rl_a", 32'(i2.data_a), 32'(av(5 + c)));
        check("rl_b", 32'(i2.data_b), 32'(bv(c - 1)));
      end
      if (c == 2) check("rl_serving", 32'(i2.serving), 0);
    end
    i1.reload = 1'b0;
    check("rl_count_hold", i2.rd_count, 24);
    check("rl_err_hold", 32'(i2.err_oob), 1);
    i1.load_done = 1'b1;
    step();
    i1.load_done = 1'b0;
    check("re_serving", 32'(i2.serving), 1);
    check("re_count", i2.rd_count, 0);
    check("re_err", 32'(i2.err_oob), 0);

    for (int c = 0; c < 6; c++) begin
      if (c < 4) rd(c, c);
      else i1.req = 1'b0;
      rst = (c == 2);
      step();
      if (c >= 2) begin
        check("mr_v3", 32'(i3.data_valid), 0);
        check("mr_v1", 32'(i1.data_valid), 0);
      end
      if (c == 2) begin
        check("mr_wr_ready", 32'(i1.wr_ready), 1);
        check("mr_serving", 32'(i1.serving), 0);
        check("mr_count", i3.rd_count, 0);
        check("mr_err", 32'(i1.err_oob), 0);
        check("mr_data_a", 32'(i3.data_a), 0);
        check("mr_data_b", 32'(i1.data_b), 0);
      end
    end
    rst = 1'b0;
    check("mr_load_count", i1.rd_count, 0);
    i1.load_done = 1'b1;
    step();
    i1.load_done = 1'b0;
    rd(4, 13);
    step();
    i1.req = 1'b0;
    check("keep_v", 32'(i1.data_valid), 1);
    check("keep_a", 32'(i1.data_a), 32'(av(4)));
    check("keep_b", 32'(i1.data_b), 32'(bv(13)));
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
